// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle for the iterative multiplier.
// The master side issues operands and consumes the product.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 a_signed;
  logic                 b_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, a_signed, b_signed, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: magnitudes are multiplied over WIDTH cycles
// through a single WIDTH-bit adder, then the sign is applied in one fix-up cycle.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic                 neg;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     add_in2;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic                 accept;
  logic                 last_step;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  assign accept    = (state == IDLE) && bus.in_valid && !flush;
  assign last_step = (count == CW'(WIDTH - 1));

  // A clear multiplier bit adds zero, leaving the high half unchanged.
  assign add_in2 = lo[0] ? mcand : '0;

  adder #(.WIDTH(WIDTH)) u_adder (
    .cin  (1'b0),
    .in1  (hi),
    .in2  (add_in2),
    .out  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid)  state_nxt = CALC;
      CALC: if (last_step)     state_nxt = FIX;
      FIX:                     state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        count <= '0;
      else if (state == CALC)
        count <= count + CW'(1);
    end
  end

  // Operand/accumulator stage: {cout, hi, lo} shifts right once per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand <= magnitude(bus.a, bus.a_signed);
      lo    <= magnitude(bus.b, bus.b_signed);
      hi    <= '0;
      neg   <= (bus.a_signed & bus.a[WIDTH-1]) ^ (bus.b_signed & bus.b[WIDTH-1]);
    end else if (state == CALC) begin
      hi <= {add_cout, add_sum[WIDTH-1:1]};
      lo <= {add_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Fix-up stage: sign applied to the full-width magnitude product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prod_q <= '0;
    else if (state == FIX && !flush)
      prod_q <= neg ? negate({hi, lo}) : {hi, lo};
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = prod_q;
endmodule

module adder #(
  parameter int WIDTH = 32
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             cout
);
  assign {cout, out} = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, cin};
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=32): products, latency,
// backpressure, flush and asynchronous reset abort.
module tb_seq_multiplier;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic as, input logic bs,
                          output logic [2*W-1:0] p, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.a_signed = as; bus.b_signed = bs;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus.product;
  endtask

  task automatic start_only(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.a_signed = 1'b0; bus.b_signed = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.product !== 64'h0) begin errors++; $display("FAIL reset_product got %h want 0", bus.product); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [2*W-1:0] p; int lat;
    bus.out_ready = 1'b1;
    issue_op(32'd3, 32'd5, 1'b0, 1'b0, p, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL u3x5_latency got %0d want 34", lat); end
    checks++; if (p !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL u3x5_product got %h want f", p); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL u3x5_release got vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
    issue_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, p, lat);
    checks++; if (p !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL u_max_product got %h want fffffffe00000001", p); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    logic [2*W-1:0] p; int lat;
    issue_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, p, lat);
    checks++; if (p !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL s_m1xm1 got %h want 1", p); end
    @(posedge clk); #1;
    issue_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, p, lat);
    checks++; if (p !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL s_minxmin got %h want 4000000000000000", p); end
    @(posedge clk); #1;
    issue_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, p, lat);
    checks++; if (p !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL s_minx1 got %h want ffffffff80000000", p); end
    @(posedge clk); #1;
    issue_op(32'hFFFF_FFF9, 32'd6, 1'b1, 1'b1, p, lat);
    checks++; if (p !== 64'hFFFF_FFFF_FFFF_FFD6) begin errors++; $display("FAIL s_m7x6 got %h want ffffffffffffffd6", p); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL s_m7x6_latency got %0d want 34", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_mixed();
    logic [2*W-1:0] p; int lat;
    issue_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, p, lat);
    checks++; if (p !== 64'hFFFF_FFFF_0000_0001) begin errors++; $display("FAIL mix_su got %h want ffffffff00000001", p); end
    @(posedge clk); #1;
    issue_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, p, lat);
    checks++; if (p !== 64'hFFFF_FFFF_0000_0001) begin errors++; $display("FAIL mix_us got %h want ffffffff00000001", p); end
    @(posedge clk); #1;
    issue_op(32'h0, 32'hFFFF_FFF9, 1'b1, 1'b1, p, lat);
    checks++; if (p !== 64'h0) begin errors++; $display("FAIL zero_neg got %h want 0", p); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL zero_latency got %0d want 34", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] p; int lat; int bad;
    bus.out_ready = 1'b0;
    issue_op(32'd7, 32'd6, 1'b0, 1'b0, p, lat);
    checks++; if (p !== 64'd42) begin errors++; $display("FAIL bp_product got %h want 2a", p); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.product !== 64'd42 || bus.in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stall_stable got %0d bad cycles want 0", bad); end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_vld got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_flush_and_reset();
    logic [2*W-1:0] p; int lat; int seen;
    start_only(32'd3, 32'd5);
    repeat (6) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle got rdy=%b vld=%b want 1/0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.product !== 64'd42) begin errors++; $display("FAIL flush_product_kept got %h want 2a", bus.product); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_output got %0d valid cycles want 0", seen); end
    @(negedge clk); bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0; flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_blocks_accept got rdy=%b want 1", bus.in_ready); end
    start_only(32'd9, 32'd9);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== 64'h0) begin errors++; $display("FAIL rst_abort got rdy=%b vld=%b prod=%h want 1/0/0", bus.in_ready, bus.out_valid, bus.product); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_output got %0d valid cycles want 0", seen); end
    issue_op(32'd7, 32'd6, 1'b0, 1'b0, p, lat);
    checks++; if (p !== 64'd42) begin errors++; $display("FAIL post_abort_product got %h want 2a", p); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL post_abort_latency got %0d want 34", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.a_signed = 1'b0; bus.b_signed = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_mixed();
    test_backpressure();
    test_flush_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
